// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit of the E stage.
//
// Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and owns the architectural
// HI/LO registers. The result is computed into shadow registers on the start edge.
// HI/LO only change on the completion edge, so an MFHI/MFLO issued during RUN reads
// the values from before the op.
//
// Optional feature: define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (ops 7-10),
// which accumulate into {HI,LO}. When it is undefined these codes decode as NOP.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   Start  in   1   op valid this cycle
//   MDUOp  in   4   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7-10 MADD/MADDU/MSUB/MSUBU
//   A      in   32  rs operand
//   B      in   32  rt operand
//   Busy   out  1   multi-cycle op in flight
//   HI     out  32  architectural HI
//   LO     out  32  architectural LO
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [31:0] MultLast = 32'(MULT_CYCLES - 1);
  localparam logic [31:0] DivLast  = 32'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        wb_en_q, wb_en_d;   // cleared for divide-by-zero: HI/LO left untouched
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_sh_q, hi_sh_d, lo_sh_q, lo_sh_d;

  // Datapath, evaluated on the start edge.
  logic [63:0] prod_u, prod_s;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0] last;

  // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Signed divide via magnitudes: 0x80000000 has magnitude 0x80000000 as unsigned,
  // so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q_s   = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = A[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u   = (B == 32'd0) ? 32'd0 : A / B;
  assign r_u   = (B == 32'd0) ? 32'd0 : A % B;

  assign last = is_div_q ? DivLast : MultLast;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    wb_en_d  = wb_en_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_sh_d  = hi_sh_q;
    lo_sh_d  = lo_sh_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          case (MDUOp)
            4'd1, 4'd2: begin
              state_d  = StRun;
              cnt_d    = 32'd0;
              is_div_d = 1'b0;
              wb_en_d  = 1'b1;
              {hi_sh_d, lo_sh_d} = (MDUOp == 4'd1) ? prod_s : prod_u;
            end
            4'd3, 4'd4: begin
              state_d  = StRun;
              cnt_d    = 32'd0;
              is_div_d = 1'b1;
              wb_en_d  = (B != 32'd0);
              hi_sh_d  = (MDUOp == 4'd3) ? r_s : r_u;
              lo_sh_d  = (MDUOp == 4'd3) ? q_s : q_u;
            end
            4'd5: hi_d = A;
            4'd6: lo_d = A;
`ifdef MDU_MADD_EN
            // Accumulator is {HI,LO} as sampled on the start edge.
            4'd7, 4'd8, 4'd9, 4'd10: begin
              state_d  = StRun;
              cnt_d    = 32'd0;
              is_div_d = 1'b0;
              wb_en_d  = 1'b1;
              unique case (MDUOp)
                4'd7:    {hi_sh_d, lo_sh_d} = {hi_q, lo_q} + prod_s;
                4'd8:    {hi_sh_d, lo_sh_d} = {hi_q, lo_q} + prod_u;
                4'd9:    {hi_sh_d, lo_sh_d} = {hi_q, lo_q} - prod_s;
                default: {hi_sh_d, lo_sh_d} = {hi_q, lo_q} - prod_u;
              endcase
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        // Start is ignored here, including on the completion edge.
        if (cnt_q == last) begin
          state_d = StIdle;
          cnt_d   = 32'd0;
          if (wb_en_q) begin
            hi_d = hi_sh_q;
            lo_d = lo_sh_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 32'd0;
      is_div_q <= 1'b0;
      wb_en_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_sh_q  <= 32'd0;
      lo_sh_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      wb_en_q  <= wb_en_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_sh_q  <= hi_sh_d;
      lo_sh_q  <= lo_sh_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu (default parameters 5/10).
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_err = 0;

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op for exactly one rising edge; caller is positioned at a negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDUOp = 4'd0;
  endtask

  // Count negedges with Busy high (bounded); returns at the first negedge with Busy low.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cnt = 0;
    @(negedge clk);
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    MDUOp = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1. MULT -2 * 3 = -6
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult_busy", 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // 2. DIVU 100/7, DIV -7/2, DIV 0x80000000/-1
    issue(4'd4, 32'd100, 32'd7);
    wait_done("divu_busy", 10);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_busy", 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf_busy", 10);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // 3. MTHI then divide by zero leaves HI/LO alone
    issue(4'd5, 32'h0000_1234, 32'd0);
    wait_done("mthi_busy", 0);
    check("mthi_hi", HI, 32'h0000_1234);
    issue(4'd3, 32'd5, 32'd0);
    wait_done("div0_busy", 10);
    check("div0_hi", HI, 32'h0000_1234);
    check("div0_lo", LO, 32'h8000_0000);

    // Undefined op code is a NOP
    issue(4'd12, 32'd77, 32'd77);
    wait_done("undef_busy", 0);
    check("undef_hi", HI, 32'h0000_1234);
    check("undef_lo", LO, 32'h8000_0000);

    // 4. Async reset during a MULT; HI/LO hold pre-op values while running
    issue(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    check("run_busy", {31'd0, Busy}, 32'd1);
    check("run_hi_stable", HI, 32'h0000_1234);
    check("run_lo_stable", LO, 32'h8000_0000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd6, 32'd9, 32'd0);
    wait_done("mtlo_busy", 0);
    check("mtlo_lo", LO, 32'd9);
    check("mtlo_hi", HI, 32'd0);
    // The aborted MULT must not complete later
    repeat (6) @(negedge clk);
    check("abort_lo", LO, 32'd9);

    // 5. Start during RUN is ignored; MTLO right after completion is accepted
    issue(4'd2, 32'h0001_0000, 32'h0001_0000);
    issue(4'd2, 32'd5, 32'd5);
    wait_done("ign_busy", 4);
    check("ign_hi", HI, 32'd1);
    check("ign_lo", LO, 32'd0);
    issue(4'd6, 32'h0000_00AB, 32'd0);
    @(negedge clk);
    check("post_mtlo_lo", LO, 32'h0000_00AB);
    check("post_mtlo_hi", HI, 32'd1);

    // 6. MADDU accumulate (or NOP when compiled out)
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_done("maddu_busy", 5);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    wait_done("maddu_busy", 0);
    check("maddu_hi", HI, 32'd0);
    check("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
